ui_control: RTL

UI_CONTROL -- requirements
Module: ui_control

---
 rtl/ui_control_if.sv | 27 ++
 rtl/ui_control.sv | 80 ++++++++
 2 files changed

// File: rtl/ui_control_if.sv
// ui_control_if: bundles the button inputs, draw-complete pulse and the
// strobe/status outputs of ui_control.
// Ports: master = stimulus side (drives buttons and i_draw_done), slave = ui_control.
interface ui_control_if;
  logic       i_btn_setX;
  logic       i_btn_setY;
  logic       i_btn_setCol;
  logic       i_btn_go;
  logic       i_draw_done;
  logic       o_setX;
  logic       o_setY;
  logic       o_setCol;
  logic       o_start;
  logic       o_done;
  logic       o_busy;
  logic [7:0] o_lines;

  modport master (
    output i_btn_setX, i_btn_setY, i_btn_setCol, i_btn_go, i_draw_done,
    input  o_setX, o_setY, o_setCol, o_start, o_done, o_busy, o_lines
  );

  modport slave (
    input  i_btn_setX, i_btn_setY, i_btn_setCol, i_btn_go, i_draw_done,
    output o_setX, o_setY, o_setCol, o_start, o_done, o_busy, o_lines
  );
endinterface

// File: rtl/ui_control.sv
// ui_control: synchronizes four async push buttons, turns presses into one-cycle
// load strobes, and sequences a line draw (IDLE -> START -> WAIT -> COMMIT).
// Ports: clk, reset (async active-low), ui (slave: buttons/draw_done in; strobes, busy, line count out).
module ui_control #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input logic       clk,
  input logic       reset,
  ui_control_if.slave ui
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] START  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  // Button vector bit order: [3]=go, [2]=setCol, [1]=setY, [0]=setX
  logic [3:0]                   btn_raw;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                   hist_q;
  logic [3:0]                   btn_sync;
  logic [3:0]                   btn_rise;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [2:0] set_q;
  logic [7:0] lines_q;

  assign btn_raw  = {ui.i_btn_go, ui.i_btn_setCol, ui.i_btn_setY, ui.i_btn_setX};
  assign btn_sync = sync_q[SYNC_STAGES-1];
  // History always tracks the synchronized level, so an edge seen while busy
  // is consumed rather than replayed once the FSM returns to IDLE.
  assign btn_rise = btn_sync & ~hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      hist_q <= btn_sync;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (btn_rise[3]) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (ui.i_draw_done) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      set_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      // Set strobes only fire from IDLE; a go edge in the same cycle does not suppress them.
      set_q   <= (state_q == IDLE) ? btn_rise[2:0] : 3'b000;
      // Count on the edge that enters COMMIT; natural 8-bit wrap.
      if (state_q == WAIT && ui.i_draw_done) begin
        lines_q <= lines_q + 8'd1;
      end
    end
  end

  assign ui.o_setX   = set_q[0];
  assign ui.o_setY   = set_q[1];
  assign ui.o_setCol = set_q[2];
  assign ui.o_start  = (state_q == START);
  assign ui.o_done   = (state_q == COMMIT);
  assign ui.o_busy   = (state_q != IDLE);
  assign ui.o_lines  = lines_q;

endmodule
